// File: rtl/approx_umul_pipe.sv
// Two-stage pipelined unsigned multiplier. Each transaction selects exact or
// pair-OR approximate low rows. A counter tracks delivered approximate results.
module approx_umul_pipe #(
  parameter int WIDTH       = 8,
  parameter int APPROX_ROWS = 4,
  parameter int CUT_COL     = 6,
  parameter int CNT_W       = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_x,
  input  logic [WIDTH-1:0]   in_y,
  input  logic               in_approx,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_z,
  output logic               out_approx,
  output logic [CNT_W-1:0]   res_cnt
);

  localparam int PW    = 2 * WIDTH;
  localparam int HW    = 2 * WIDTH - APPROX_ROWS;
  localparam int PAIRS = APPROX_ROWS / 2;

  localparam logic [PW-1:0] LOW_MASK  = (PW'(1) << APPROX_ROWS) - PW'(1);
  localparam logic [PW-1:0] KEEP_MASK = ~((PW'(1) << CUT_COL) - PW'(1));

  logic advance;

  logic [PW-1:0] x_ext;
  logic [PW-1:0] y_ext;

  logic          s1_valid_q, s1_valid_d;
  logic [HW-1:0] h_q, h_d;
  logic [PW-1:0] a_q, a_d;
  logic [PW-1:0] e_q, e_d;
  logic          s1_approx_q, s1_approx_d;

  logic             out_valid_q, out_valid_d;
  logic [PW-1:0]    out_z_q, out_z_d;
  logic             out_approx_q, out_approx_d;
  logic [CNT_W-1:0] res_cnt_q, res_cnt_d;

  logic [PW-1:0] row_lo;
  logic [PW-1:0] row_hi;
  logic          bit_lo;
  logic          bit_hi;

  // The pipeline stalls as a whole only when a result is waiting for the consumer.
  assign advance  = !out_valid_q || out_ready;
  assign in_ready = advance;

  assign x_ext = {{WIDTH{1'b0}}, in_x};
  assign y_ext = {{WIDTH{1'b0}}, in_y};

  // The high rows are always exact. The product fits in HW bits.
  assign h_d = HW'(y_ext * (x_ext >> APPROX_ROWS));
  assign e_d = y_ext * (x_ext & LOW_MASK);

  // Each row pair collapses into one OR vector. Columns below CUT_COL are dropped.
  always_comb begin
    a_d    = '0;
    row_lo = '0;
    row_hi = '0;
    bit_lo = 1'b0;
    bit_hi = 1'b0;
    for (int k = 0; k < PAIRS; k++) begin
      bit_lo = |(x_ext & (PW'(1) << (2 * k)));
      bit_hi = |(x_ext & (PW'(1) << (2 * k + 1)));
      row_lo = {PW{bit_lo}} & (y_ext << (2 * k));
      row_hi = {PW{bit_hi}} & (y_ext << (2 * k + 1));
      a_d    = a_d + ((row_lo | row_hi) & KEEP_MASK);
    end
  end

  assign s1_valid_d  = in_valid;
  assign s1_approx_d = in_approx;

  assign out_valid_d  = s1_valid_q;
  assign out_approx_d = s1_approx_q;
  assign out_z_d      = (PW'(h_q) << APPROX_ROWS) + (s1_approx_q ? a_q : e_q);

  always_comb begin
    res_cnt_d = res_cnt_q;
    if (out_valid_q && out_ready && out_approx_q) begin
      res_cnt_d = res_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q   <= 1'b0;
      h_q          <= '0;
      a_q          <= '0;
      e_q          <= '0;
      s1_approx_q  <= 1'b0;
      out_valid_q  <= 1'b0;
      out_z_q      <= '0;
      out_approx_q <= 1'b0;
      res_cnt_q    <= '0;
    end else begin
      res_cnt_q <= res_cnt_d;
      if (advance) begin
        s1_valid_q   <= s1_valid_d;
        h_q          <= h_d;
        a_q          <= a_d;
        e_q          <= e_d;
        s1_approx_q  <= s1_approx_d;
        out_valid_q  <= out_valid_d;
        out_z_q      <= out_z_d;
        out_approx_q <= out_approx_d;
      end
    end
  end

  assign out_valid  = out_valid_q;
  assign out_z      = out_z_q;
  assign out_approx = out_approx_q;
  assign res_cnt    = res_cnt_q;

endmodule
